ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
Two-master arbiter sharing the burst-mode external RAM controller port (4M x 32, fixed 8-word bursts, wrap within 8-word line).
- Grants one requester per burst, issues a single-cycle strobe and counts BURST_LEN acks before releasing the RAM.
- Routes per-word write data and read data, and steers acks to the granted master.
- Sits between the memory requesters (m0: video/DMA, m1: CPU cache) and the RAM port.

Parameters:
ADDR_W, 22, word address width
DATA_W, 32, data width
BURST_LEN, 8, words per burst; power of two; ack counter is log2(BURST_LEN) bits

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
m0_stb  in  1  master 0 request, level; held until its last ack
m0_we  in  1  master 0 write when 1, read when 0
m0_addr  in  ADDR_W  master 0 start word address
m0_din  in  DATA_W  master 0 write data, next word each acked cycle
m0_dout  out  DATA_W  read data to master 0
m0_ack  out  1  per-word ack to master 0
m1_stb, m1_we, m1_addr, m1_din, m1_dout, m1_ack  (same as m0, for master 1)
ram_stb  out  1  RAM request, one-cycle pulse
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM start address
ram_dout  out  DATA_W  write data to RAM data_in
ram_din  in  DATA_W  read data from RAM data_out
ram_ack  in  1  per-word RAM ack; write ack combinational, read ack registered
grant  out  2  one-hot current owner; 00 when idle
busy  out  1  1 in ISSUE or XFER

Behaviour:
- Reset (async, rst_n=0): state IDLE, grant=00, ram_stb=0, ram_we=0, ram_addr=0, ack count=0, last=1 (m0 wins the first tie), all mN_ack=0. rst_n must be asserted together with the RAM reset; the arbiter does not recover a burst the RAM is still running.
- States:
  - IDLE: samples m0_stb/m1_stb.
    - Neither request: stay.
    - One request: grant it.
    - Both: grant the master != last.
    - On grant: latch we/addr into ram_we/ram_addr, set grant, go ISSUE.
  - ISSUE: ram_stb=1 for exactly this cycle; count=0; go XFER.
  - XFER: ram_stb=0. Each cycle with ram_ack=1 increments count.
    - Ack with count==BURST_LEN-1: set last=owner, clear grant, count=0, go IDLE.
    - Acks before that: stay.
    - ram_ack=0: stay, with no timeout unless the optional feature is enabled.
- Routing (combinational):
  - ram_dout = owner's mN_din; 0 when idle.
  - m0_dout = m1_dout = ram_din, broadcast.
  - mN_ack = ram_ack & grant[N] & (state==XFER).
- Master rule: a master clears stb at the clock edge ending its BURST_LEN-th ack. IDLE is entered on that same edge, so stb still high in IDLE is a new request.
- ram_we/ram_addr are stable from ISSUE through the end of XFER.
- Minimum gap between bursts: 1 IDLE cycle plus ISSUE.
- mN_we/mN_addr changes while not granted are ignored until sampled in IDLE.
- Writes: the master must present word k on mN_din during its k-th ack cycle. The path is combinational, with no arbiter register.
- Stray ram_ack in IDLE/ISSUE: ignored, not forwarded.

Optional Feature:
RAM_ARB_FIXED_PRIO_EN
- Defined: m0 always wins a tie in IDLE; last is still updated but not used.
- Undefined: round-robin as above.
- Burst atomicity is identical in both cases.

Decomposition:
- Shared package ram_arb_pkg:
  - state enum: IDLE=2'd0, ISSUE=2'd1, XFER=2'd2
  - BURST_LEN default
  - grant encodings GNT_NONE, GNT_M0, GNT_M1
- One natural sub-module: ram_arb_rr, a 2-input round-robin picker (req[1:0], last, out one-hot grant) with the fixed-priority macro applied inside it.

Test Plan:
- Reset, then m0 read at 0x000005 (m1 idle) -> ram_stb exactly one cycle, 2 cycles after stb seen; ram_addr=0x000005, ram_we=0; 8 m0_ack cycles; m1_ack never 1; m0_dout matches the RAM model for word addresses 5,6,7,0,1,2,3,4 of the line.
- m0 and m1 read requests in the same cycle after reset -> m0 burst first (8 acks), one IDLE cycle, then m1 burst (8 acks); grant sequence 01,00,10.
- m0 requests again immediately while m1 is pending, with last=m0 -> m1 granted; with RAM_ARB_FIXED_PRIO_EN defined -> m0 granted.
- m1 write at 0x000010 with m1_din = 0xA0000000+k on k-th ack -> ram_we=1, ram_dout equals those 8 values on the 8 ack cycles; m0_ack stays 0.
- rst_n pulled low during the 4th ack of an m0 burst (RAM reset together) -> grant=00, busy=0, ram_stb=0 immediately (async); a fresh m1 request after release is served normally.
- Injected ram_ack while IDLE -> no mN_ack asserted; ack count stays 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-master RAM arbiter.
//   arb_state_e    : arbiter FSM state encoding
//   BURST_LEN_DEF  : default words per burst
//   GNT_*          : one-hot grant encodings (bit N = master N owns the RAM)
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2
    } arb_state_e;

    localparam int BURST_LEN_DEF = 8;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: two-input grant picker.
//   req[1:0] : request levels (bit N = master N)
//   last     : owner of the previous burst (0 = m0, 1 = m1)
//   gnt[1:0] : one-hot pick, GNT_NONE when nothing is requested
// Build option RAM_ARB_FIXED_PRIO_EN: m0 wins every tie and last is ignored;
// otherwise a tie goes to the master that did not own the previous burst.
import ram_arb_pkg::*;

module ram_arb_rr (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b01: gnt = GNT_M0;
            2'b10: gnt = GNT_M1;
            2'b11: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                gnt = GNT_M0;
`else
                gnt = last ? GNT_M0 : GNT_M1;
`endif
            end
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one burst-mode RAM controller port between m0
// (video/DMA) and m1 (CPU cache). One owner per burst: the owner's we/addr
// are latched in IDLE, a single-cycle ram_stb is issued, and BURST_LEN acks
// are counted before the RAM is released.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mN_stb/we/addr/din  : master N request level, direction, start address,
//                         per-word write data
//   mN_dout, mN_ack     : broadcast read data, per-word ack (owner only)
//   ram_stb/we/addr     : RAM request pulse, direction, start address
//   ram_dout, ram_din   : write data to RAM, read data from RAM
//   ram_ack             : per-word RAM ack
//   grant, busy         : one-hot owner (00 idle), 1 in ISSUE/XFER
// Build option RAM_ARB_FIXED_PRIO_EN (see ram_arb_rr): m0 wins ties.
import ram_arb_pkg::*;

module ram_arbiter #(
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_din,
    output logic [DATA_W-1:0] m0_dout,
    output logic              m0_ack,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_din,
    output logic [DATA_W-1:0] m1_dout,
    output logic              m1_ack,
    output logic              ram_stb,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    input  logic [DATA_W-1:0] ram_din,
    input  logic              ram_ack,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    arb_state_e       state, nstate;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [1:0]       pick;
    logic             xfer_ack;

    ram_arb_rr u_rr (
        .req  ({m1_stb, m0_stb}),
        .last (last),
        .gnt  (pick)
    );

    // Only acks seen during XFER belong to a burst; strays elsewhere are dropped.
    assign xfer_ack = ram_ack & (state == XFER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (pick != GNT_NONE) nstate = ISSUE;
            ISSUE:   nstate = XFER;
            XFER:    if (ram_ack && cnt == CNT_LAST) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= GNT_NONE;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            cnt      <= '0;
            last     <= 1'b1;   // so m0 wins the first tie
        end else begin
            case (state)
                IDLE: if (pick != GNT_NONE) begin
                    grant    <= pick;
                    ram_we   <= pick[1] ? m1_we   : m0_we;
                    ram_addr <= pick[1] ? m1_addr : m0_addr;
                end
                ISSUE: cnt <= '0;
                XFER: if (ram_ack) begin
                    if (cnt == CNT_LAST) begin
                        last  <= grant[1];
                        grant <= GNT_NONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_stb = (state == ISSUE);
    assign busy    = (state != IDLE);
    assign m0_ack  = xfer_ack & grant[0];
    assign m1_ack  = xfer_ack & grant[1];
    assign m0_dout = ram_din;
    assign m1_dout = ram_din;

    // Write data is steered straight through so the owner's word k lands
    // on the RAM in its k-th ack cycle.
    always_comb begin
        ram_dout = '0;
        if (grant[0])      ram_dout = m0_din;
        else if (grant[1]) ram_dout = m1_din;
    end

endmodule
